// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : seven_seg_scan_ctrl
// Brief   : 4-digit common-anode seven-segment scan controller with dead-cycle
//           blanking between digits and optional leading-zero suppression.
// Revision: 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        digit_tick
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_div_last = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       c_seg_off  = 7'b1111111;
  localparam logic [3:0]       c_an_off   = 4'b1111;

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_hold_val;
  logic [3:0]       r_hold_dp;
  logic [1:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_div, w_div_nxt;
  logic             w_tick_nxt;
  logic [3:0]       w_an_nxt;
  logic [6:0]       w_seg_nxt;
  logic             w_dp_nxt;
  logic [3:0]       w_nib;
  logic [3:0]       w_zero_upper;
  logic             w_lz_blank;

  function automatic logic [6:0] f_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  // w_zero_upper[k]: nibbles k..3 all zero; digit 0 is never blanked
  assign w_zero_upper[3] = (r_hold_val[15:12] == 4'h0);
  assign w_zero_upper[2] = w_zero_upper[3] && (r_hold_val[11:8] == 4'h0);
  assign w_zero_upper[1] = w_zero_upper[2] && (r_hold_val[7:4] == 4'h0);
  assign w_zero_upper[0] = 1'b0;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_div_nxt   = r_div;
    w_tick_nxt  = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = 2'd0;
      w_div_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_DRIVE;
          w_idx_nxt   = 2'd0;
          w_div_nxt   = '0;
        end
        S_DRIVE: begin
          if (r_div == c_div_last) begin
            w_state_nxt = S_BLANK;
            w_div_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_div_nxt = r_div + CNT_W'(1);
          end
        end
        S_BLANK: w_state_nxt = S_DRIVE;
        default: begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 2'd0;
          w_div_nxt   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state view so they track state/idx
  assign w_nib      = r_hold_val[{w_idx_nxt, 2'b00} +: 4];
  assign w_lz_blank = blank_lz && w_zero_upper[w_idx_nxt];

  always_comb begin
    w_an_nxt  = c_an_off;
    w_seg_nxt = c_seg_off;
    w_dp_nxt  = 1'b1;
    if (w_state_nxt == S_DRIVE) begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = w_lz_blank ? c_seg_off : ~f_glyph(w_nib);
      w_dp_nxt  = ~r_hold_dp[w_idx_nxt];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_hold_val <= 16'h0000;
      r_hold_dp  <= 4'h0;
      r_idx      <= 2'd0;
      r_div      <= '0;
      an         <= c_an_off;
      seg        <= c_seg_off;
      dp         <= 1'b1;
      digit_tick <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_div      <= w_div_nxt;
      an         <= w_an_nxt;
      seg        <= w_seg_nxt;
      dp         <= w_dp_nxt;
      digit_tick <= w_tick_nxt;
      if (load) begin
        r_hold_val <= value;
        r_hold_dp  <= dp_in;
      end
    end
  end

endmodule
`default_nettype wire
